ahb_slave_ctrl: RTL and testbench
=================================

Name: ahb_slave_ctrl

Overview:
- Control FSM that sequences the AHB slave-1 datapath (address/data capture registers, address comparator, commit register).
- Decodes the AHB-lite transfer and drives the load enables `sa1`, `sw1` and `ld_q`.
- Inserts a parameterised number of wait states and returns `sl_rdy_1` and `slrsp_1`, giving a two-cycle ERROR response on an address mismatch.
- Sits between the bus interconnect and the slave datapath; keeps 8-bit write and error counters for debug.

Parameters:
- WAIT_STATES, 2, number of data-phase wait cycles inserted per accepted matched transfer (0..15).
- CNT_W, 8, width of the write and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- hsel_1  in  1  slave-1 select from the address decoder.
- htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write, 0 = read (address-phase qualifier).
- hready_in  in  1  bus-wide HREADY (previous transfer complete).
- addr_match  in  1  comparator result, HADDR1 == sadd (address phase).
- sa1  out  1  address-register load enable (combinational).
- sw1  out  1  write-data-register load enable.
- ld_q  out  1  commit-register load enable (registered).
- sl_rdy_1  out  1  slave HREADYOUT.
- slrsp_1  out  1  slave HRESP (1 = ERROR).
- wr_cnt  out  CNT_W  completed matched writes, saturating.
- err_cnt  out  CNT_W  ERROR responses issued, saturating.

Behaviour:
- Reset: synchronous. While rst=1 at a clock edge:
  - state <= IDLE; wait counter, write flag, ld_q, wr_cnt and err_cnt <= 0.
  - sa1 and sw1 are forced 0 while rst=1.
  - Outputs after reset: sl_rdy_1=1, slrsp_1=0.
- accept = hsel_1 & htrans[1] & hready_in & sl_rdy_1 & ~rst.
  - IDLE (00) and BUSY (01) are never accepted.
- sa1 = accept (same cycle as the address phase), so the address register captures HADDR1 on that edge.
- States and outputs:
  - IDLE: sl_rdy_1=1, slrsp_1=0.
  - WAIT: sl_rdy_1=0, slrsp_1=0.
  - DATA: sl_rdy_1=1, slrsp_1=0.
  - ERR1: sl_rdy_1=0, slrsp_1=1.
  - ERR2: sl_rdy_1=1, slrsp_1=1.
- Transitions (evaluated on accept, from IDLE, DATA or ERR2):
  - addr_match=1 and WAIT_STATES>0: go to WAIT, load wait counter with WAIT_STATES-1, latch write flag = hwrite.
  - addr_match=1 and WAIT_STATES=0: go to DATA, latch write flag.
  - addr_match=0: go to ERR1; write flag cleared.
  - No accept in DATA or ERR2: go to IDLE.
- WAIT: decrement the counter each cycle; when the counter is 0, go to DATA. A matched transfer therefore shows exactly WAIT_STATES cycles of sl_rdy_1=0.
- ERR1 always goes to ERR2 next cycle.
- Back-to-back: a new transfer accepted in the final DATA or ERR2 cycle proceeds with no IDLE bubble.
- sw1 = (state==DATA) & write flag. It is asserted only in the completing data-phase cycle, when HWDATA1 is valid.
- ld_q is registered: it goes high for exactly 1 cycle, the cycle after sw1=1. This commits SD into Q once the data register holds the new value.
- wr_cnt increments on the edge where sw1=1; err_cnt increments on entry to ERR1. Both saturate at 2^CNT_W-1.
- Mid-transfer input changes: hsel_1, htrans and addr_match changing during WAIT, DATA or ERR1 do not alter the transfer already in progress. Only the address phase is sampled.
- Reset mid-operation: the FSM returns to IDLE next edge. Any pending sw1 or ld_q is cancelled and counters clear.
- Reads: no sw1 and no ld_q; timing is otherwise identical to writes.

Test Plan:
- Reset: rst=1 for 2 cycles with hsel_1=1, htrans=10 → sa1=0, sw1=0, ld_q=0, sl_rdy_1=1, slrsp_1=0, wr_cnt=0, err_cnt=0.
- Matched write, WAIT_STATES=2: accept in cycle 0 → sa1=1 in cycle 0; sl_rdy_1=0 in cycles 1–2; DATA in cycle 3 with sw1=1 and sl_rdy_1=1; ld_q=1 in cycle 4; wr_cnt=1.
- Mismatch: addr_match=0, htrans=10 → sl_rdy_1/slrsp_1 = 0/1 then 1/1; sw1 never asserted; err_cnt=1.
- Back-to-back: matched write, then a matched read accepted in the DATA cycle → second sa1 coincides with the first write's sw1; the read shows no sw1; wr_cnt=1.
- Filtering: htrans=01 or 00 with hsel_1=1, or hready_in=0 → no sa1 and state stays IDLE. Reset asserted during WAIT → IDLE next cycle, no sw1 or ld_q.
- Saturation: 260 matched writes with CNT_W=8 → wr_cnt holds at 255.

Source files
------------

// File: rtl/ahb_slave_ctrl_if.sv
// ahb_slave_ctrl_if: bus-side and datapath-control signals of the AHB slave-1 controller
interface ahb_slave_ctrl_if #(parameter int CNT_W = 8);
  logic             hsel_1;
  logic [1:0]       htrans;
  logic             hwrite;
  logic             hready_in;
  logic             addr_match;
  logic             sa1;
  logic             sw1;
  logic             ld_q;
  logic             sl_rdy_1;
  logic             slrsp_1;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport slave (
    input  hsel_1, htrans, hwrite, hready_in, addr_match,
    output sa1, sw1, ld_q, sl_rdy_1, slrsp_1, wr_cnt, err_cnt
  );
  modport master (
    output hsel_1, htrans, hwrite, hready_in, addr_match,
    input  sa1, sw1, ld_q, sl_rdy_1, slrsp_1, wr_cnt, err_cnt
  );
endinterface

// File: rtl/ahb_slave_ctrl.sv
// ahb_slave_ctrl: AHB-lite slave-1 control FSM with wait states, two-cycle ERROR and debug counters
module ahb_slave_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int CNT_W       = 8
) (
  input logic             clk,
  input logic             rst,
  ahb_slave_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_e;
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  state_e           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             wr_q, wr_d;
  logic             ld_q;
  logic [CNT_W-1:0] wr_cnt_q, err_cnt_q;
  logic             accept, rdy, sw1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      wr_q      <= 1'b0;
      ld_q      <= 1'b0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wr_q      <= wr_d;
      ld_q      <= sw1;
      wr_cnt_q  <= (sw1 && !(&wr_cnt_q)) ? wr_cnt_q + 1'b1 : wr_cnt_q;
      err_cnt_q <= (state_d == ERR1 && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end
  end
  assign accept = bus.hsel_1 & (bus.htrans inside {2'b10, 2'b11}) & bus.hready_in & rdy & ~rst;
  // Only the address phase (accept) is sampled; WAIT/ERR1 ignore the bus entirely
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wr_d    = wr_q;
    case (state_q)
      WAIT: begin
        wcnt_d  = wcnt_q - 1'b1;
        state_d = (wcnt_q == 4'd0) ? DATA : WAIT;
      end
      ERR1: state_d = ERR2;
      default: begin
        if (accept && bus.addr_match) begin
          state_d = (WAIT_STATES > 0) ? WAIT : DATA;
          wcnt_d  = WS_M1;
          wr_d    = bus.hwrite;
        end else if (accept) begin
          state_d = ERR1;
          wr_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end
  always_comb begin
    rdy = !(state_q == WAIT || state_q == ERR1);
    sw1 = (state_q == DATA) & wr_q & ~rst;
  end
  assign bus.sa1      = accept;
  assign bus.sw1      = sw1;
  assign bus.ld_q     = ld_q;
  assign bus.sl_rdy_1 = rdy;
  assign bus.slrsp_1  = (state_q == ERR1 || state_q == ERR2);
  assign bus.wr_cnt   = wr_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// tb_ahb_slave_ctrl: vector table plus directed sequences for the slave-1 control FSM
module tb_ahb_slave_ctrl;
  typedef struct {
    logic [6:0] in;
    logic [4:0] out;
    int         wr;
    int         er;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t v[34];
  ahb_slave_ctrl_if #(.CNT_W(8)) bus();
  ahb_slave_ctrl #(.WAIT_STATES(2), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [6:0] in, logic [4:0] out, int wr, int er);
    vec_t r;
    r.in = in; r.out = out; r.wr = wr; r.er = er;
    return r;
  endfunction
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic drive(logic [6:0] in);
    {rst, bus.hsel_1, bus.htrans, bus.hwrite, bus.hready_in, bus.addr_match} = in;
  endtask
  // in = {rst,hsel,htrans,hwrite,hready,match}; out = {sa1,sw1,ld_q,rdy,rsp}
  initial begin
    v[0]  = mk(7'b1_1_10_1_1_1, 5'b00010, 0, 0);
    v[1]  = mk(7'b1_1_10_1_1_1, 5'b00010, 0, 0);
    v[2]  = mk(7'b0_1_01_1_1_1, 5'b00010, 0, 0);
    v[3]  = mk(7'b0_1_00_1_1_1, 5'b00010, 0, 0);
    v[4]  = mk(7'b0_1_10_1_0_1, 5'b00010, 0, 0);
    v[5]  = mk(7'b0_0_10_1_1_1, 5'b00010, 0, 0);
    v[6]  = mk(7'b0_1_10_1_1_1, 5'b10010, 0, 0);
    v[7]  = mk(7'b0_0_00_0_1_0, 5'b00000, 0, 0);
    v[8]  = mk(7'b0_1_10_0_1_0, 5'b00000, 0, 0);
    v[9]  = mk(7'b0_0_00_0_1_0, 5'b01010, 0, 0);
    v[10] = mk(7'b0_0_00_0_1_0, 5'b00110, 1, 0);
    v[11] = mk(7'b0_1_10_1_1_0, 5'b10010, 1, 0);
    v[12] = mk(7'b0_1_10_1_1_1, 5'b00001, 1, 1);
    v[13] = mk(7'b0_0_00_0_1_0, 5'b00011, 1, 1);
    v[14] = mk(7'b0_0_00_0_1_0, 5'b00010, 1, 1);
    v[15] = mk(7'b0_1_10_1_1_1, 5'b10010, 1, 1);
    v[16] = mk(7'b0_0_00_0_1_0, 5'b00000, 1, 1);
    v[17] = mk(7'b0_0_00_0_1_0, 5'b00000, 1, 1);
    v[18] = mk(7'b0_1_11_0_1_1, 5'b11010, 1, 1);
    v[19] = mk(7'b0_0_00_0_1_0, 5'b00100, 2, 1);
    v[20] = mk(7'b0_0_00_0_1_0, 5'b00000, 2, 1);
    v[21] = mk(7'b0_0_00_0_1_0, 5'b00010, 2, 1);
    v[22] = mk(7'b0_0_00_0_1_0, 5'b00010, 2, 1);
    v[23] = mk(7'b0_1_10_1_1_0, 5'b10010, 2, 1);
    v[24] = mk(7'b0_0_00_0_1_0, 5'b00001, 2, 2);
    v[25] = mk(7'b0_1_10_1_1_1, 5'b10011, 2, 2);
    v[26] = mk(7'b0_0_00_0_1_0, 5'b00000, 2, 2);
    v[27] = mk(7'b0_0_00_0_1_0, 5'b00000, 2, 2);
    v[28] = mk(7'b0_0_00_0_1_0, 5'b01010, 2, 2);
    v[29] = mk(7'b0_0_00_0_1_0, 5'b00110, 3, 2);
    v[30] = mk(7'b0_1_10_1_1_1, 5'b10010, 3, 2);
    v[31] = mk(7'b1_0_00_0_1_0, 5'b00000, 3, 2);
    v[32] = mk(7'b0_0_00_0_1_0, 5'b00010, 0, 0);
    v[33] = mk(7'b0_0_00_0_1_0, 5'b00010, 0, 0);
    drive(7'b1_0_00_0_1_0);
    @(negedge clk);
    for (int i = 0; i < 34; i++) begin
      drive(v[i].in);
      #2;
      chk($sformatf("row%0d_outs", i), int'({bus.sa1, bus.sw1, bus.ld_q, bus.sl_rdy_1, bus.slrsp_1}), int'(v[i].out));
      chk($sformatf("row%0d_wr_cnt", i), int'(bus.wr_cnt), v[i].wr);
      chk($sformatf("row%0d_err_cnt", i), int'(bus.err_cnt), v[i].er);
      @(negedge clk);
    end
    begin
      int n = 0;
      drive(7'b0_1_10_0_1_1);
      @(negedge clk);
      drive(7'b0_0_00_0_1_0);
      #2;
      while (!bus.sl_rdy_1 && n < 10) begin
        n++;
        @(negedge clk);
        #2;
      end
      chk("read_wait_cycles", n, 2);
      chk("read_data_no_sw1", int'(bus.sw1), 0);
      @(negedge clk);
      #2;
      chk("read_no_ld_q", int'(bus.ld_q), 0);
    end
    for (int k = 0; k < 260; k++) begin
      @(negedge clk);
      drive(7'b0_1_10_1_1_1);
      @(negedge clk);
      drive(7'b0_0_00_0_1_0);
      @(negedge clk);
      @(negedge clk);
      if (k == 254) begin
        @(negedge clk);
        #2;
        chk("wr_cnt_at_255", int'(bus.wr_cnt), 255);
      end
    end
    @(negedge clk);
    #2;
    chk("wr_cnt_saturated", int'(bus.wr_cnt), 255);
    chk("err_cnt_after_sat", int'(bus.err_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
